// File: rtl/ddr3_app_sequencer_if.sv
// Command, write-data, read-response and DDR3 app_* signal bundle for ddr3_app_sequencer.
`timescale 1ns/1ps
interface ddr3_app_sequencer_if #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned ADDR_W  = 27,
    parameter int unsigned BURST_W = 6
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic               io_cmd_valid;
    logic               io_cmd_ready;
    logic               io_cmd_type;
    logic [ADDR_W-1:0]  io_cmd_addr;
    logic [BURST_W-1:0] io_cmd_burst_cnt;

    logic               io_wd_valid;
    logic               io_wd_ready;
    logic [DATA_W-1:0]  io_wd_data;
    logic [MASK_W-1:0]  io_wd_mask;

    logic               io_rsp_valid;
    logic [DATA_W-1:0]  io_rsp_data;
    logic               io_rsp_last;
    logic               io_rsp_credit_ret;

    logic [2:0]         io_app_cmd;
    logic               io_app_cmd_en;
    logic [ADDR_W-1:0]  io_app_addr;
    logic [BURST_W-1:0] io_app_burst_number;
    logic               io_app_cmd_ready;
    logic [DATA_W-1:0]  io_app_wdata;
    logic               io_app_wdata_en;
    logic               io_app_wdata_end;
    logic [MASK_W-1:0]  io_app_wdata_mask;
    logic               io_app_wdata_ready;
    logic [DATA_W-1:0]  io_app_rdata;
    logic               io_app_rdata_valid;
    logic               io_app_rdata_end;
    logic               io_init_calib_complete;

    logic               io_busy;
    logic               io_err_ovf;

    // Sequencer side
    modport slave (
        input  io_cmd_valid, io_cmd_type, io_cmd_addr, io_cmd_burst_cnt,
        input  io_wd_valid, io_wd_data, io_wd_mask,
        input  io_rsp_credit_ret,
        input  io_app_cmd_ready, io_app_wdata_ready,
        input  io_app_rdata, io_app_rdata_valid, io_app_rdata_end,
        input  io_init_calib_complete,
        output io_cmd_ready, io_wd_ready,
        output io_rsp_valid, io_rsp_data, io_rsp_last,
        output io_app_cmd, io_app_cmd_en, io_app_addr, io_app_burst_number,
        output io_app_wdata, io_app_wdata_en, io_app_wdata_end, io_app_wdata_mask,
        output io_busy, io_err_ovf
    );

    // Environment side: FIFOs, response consumer and DDR3 IP
    modport master (
        output io_cmd_valid, io_cmd_type, io_cmd_addr, io_cmd_burst_cnt,
        output io_wd_valid, io_wd_data, io_wd_mask,
        output io_rsp_credit_ret,
        output io_app_cmd_ready, io_app_wdata_ready,
        output io_app_rdata, io_app_rdata_valid, io_app_rdata_end,
        output io_init_calib_complete,
        input  io_cmd_ready, io_wd_ready,
        input  io_rsp_valid, io_rsp_data, io_rsp_last,
        input  io_app_cmd, io_app_cmd_en, io_app_addr, io_app_burst_number,
        input  io_app_wdata, io_app_wdata_en, io_app_wdata_end, io_app_wdata_mask,
        input  io_busy, io_err_ovf
    );
endinterface

// File: rtl/ddr3_app_sequencer.sv
// Converts queued commands plus a write-data stream into Gowin DDR3 app_* transactions,
// with multi-beat write bursts and credit-gated pipelined reads.
`timescale 1ns/1ps
module ddr3_app_sequencer #(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned ADDR_W      = 27,
    parameter int unsigned BURST_W     = 6,
    parameter int unsigned ADDR_STEP   = 8,
    parameter int unsigned RSP_CREDITS = 64
) (
    input  logic                  clk_ref,
    input  logic                  rstn,
    ddr3_app_sequencer_if.slave   bus
);
    localparam int unsigned BEATS_W = BURST_W + 1;
    localparam int unsigned CRED_W  = $clog2(RSP_CREDITS + 1);
    localparam int unsigned CSUM_W  = ((CRED_W > BEATS_W) ? CRED_W : BEATS_W) + 1;
    localparam int unsigned MASK_W  = DATA_W / 8;

    // A full burst must always fit in the response buffer, or reads could deadlock.
    if (RSP_CREDITS < (1 << BURST_W) || ADDR_STEP == 0) begin : g_bad_cfg
        $error("ddr3_app_sequencer: RSP_CREDITS must cover a maximum burst and ADDR_STEP must be nonzero");
    end

    typedef enum logic [2:0] {
        S_CALIB = 3'd0,
        S_IDLE  = 3'd1,
        S_WCMD  = 3'd2,
        S_WDATA = 3'd3,
        S_RCMD  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [BURST_W-1:0]  burst_q;
    logic [BURST_W-1:0]  beat_q;
    logic [CRED_W-1:0]   credits_q, credits_d;
    logic [CRED_W-1:0]   outst_q, outst_d;

    logic                cmd_fire;
    logic                rd_take;
    logic                rd_issue;
    logic                wd_fire;
    logic                rsp_dec;
    logic                ovf_hit;
    logic [BEATS_W-1:0]  cmd_beats;
    logic [BEATS_W-1:0]  lat_beats;
    logic [CSUM_W-1:0]   cred_sum;
    logic [CSUM_W-1:0]   outst_sum;

    assign cmd_beats = BEATS_W'(bus.io_cmd_burst_cnt) + BEATS_W'(1);
    assign lat_beats = BEATS_W'(burst_q) + BEATS_W'(1);

    // FSM state register
    always_ff @(posedge clk_ref or negedge rstn) begin
        if (!rstn) state_q <= S_CALIB;
        else       state_q <= state_d;
    end

    // Next state and combinational handshake outputs
    always_comb begin
        state_d                 = state_q;
        cmd_fire                = 1'b0;
        rd_take                 = 1'b0;
        rd_issue                = 1'b0;
        wd_fire                 = 1'b0;
        bus.io_cmd_ready        = 1'b0;
        bus.io_wd_ready         = 1'b0;
        bus.io_app_cmd          = 3'd0;
        bus.io_app_cmd_en       = 1'b0;
        bus.io_app_wdata        = '0;
        bus.io_app_wdata_en     = 1'b0;
        bus.io_app_wdata_end    = 1'b0;
        bus.io_app_wdata_mask   = '0;

        case (state_q)
            S_CALIB: begin
                if (bus.io_init_calib_complete) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!bus.io_init_calib_complete) begin
                    state_d = S_CALIB;
                end else begin
                    bus.io_cmd_ready = bus.io_cmd_valid &&
                        (!bus.io_cmd_type || (CSUM_W'(credits_q) >= CSUM_W'(cmd_beats)));
                    cmd_fire = bus.io_cmd_ready;
                    rd_take  = cmd_fire && bus.io_cmd_type;
                    if (cmd_fire) state_d = bus.io_cmd_type ? S_RCMD : S_WCMD;
                end
            end
            S_WCMD: begin
                bus.io_app_cmd_en = 1'b1;
                if (bus.io_app_cmd_ready) state_d = S_WDATA;
            end
            S_WDATA: begin
                bus.io_app_wdata_en   = bus.io_wd_valid;
                bus.io_wd_ready       = bus.io_app_wdata_ready;
                bus.io_app_wdata      = bus.io_wd_data;
                bus.io_app_wdata_mask = bus.io_wd_mask;
                bus.io_app_wdata_end  = bus.io_wd_valid && (beat_q == burst_q);
                wd_fire               = bus.io_wd_valid && bus.io_app_wdata_ready;
                if (wd_fire && (beat_q == burst_q)) state_d = S_IDLE;
            end
            S_RCMD: begin
                bus.io_app_cmd_en = 1'b1;
                bus.io_app_cmd    = 3'd1;
                if (bus.io_app_cmd_ready) begin
                    rd_issue = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_CALIB;
        endcase
    end

    assign bus.io_app_addr         = addr_q;
    assign bus.io_app_burst_number = burst_q;

    // Response-buffer credits: taken at command accept, returned per freed beat, netted and saturated
    always_comb begin
        cred_sum = CSUM_W'(credits_q)
                 - (rd_take ? CSUM_W'(cmd_beats) : CSUM_W'(0))
                 + CSUM_W'(bus.io_rsp_credit_ret);
        if (cred_sum > CSUM_W'(RSP_CREDITS)) credits_d = CRED_W'(RSP_CREDITS);
        else                                 credits_d = CRED_W'(cred_sum);
    end

    // Outstanding read beats; a stray beat with nothing outstanding flags overflow and leaves the count at 0
    always_comb begin
        ovf_hit   = bus.io_app_rdata_valid && (outst_q == '0);
        rsp_dec   = bus.io_app_rdata_valid && (outst_q != '0);
        outst_sum = CSUM_W'(outst_q)
                  + (rd_issue ? CSUM_W'(lat_beats) : CSUM_W'(0))
                  - CSUM_W'(rsp_dec);
        outst_d   = CRED_W'(outst_sum);
    end

    // Command latches and write beat counter
    always_ff @(posedge clk_ref or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
        end else begin
            if (cmd_fire) begin
                addr_q  <= bus.io_cmd_addr;
                burst_q <= bus.io_cmd_burst_cnt;
                beat_q  <= '0;
            end else if (wd_fire) begin
                beat_q  <= beat_q + BURST_W'(1);
            end
        end
    end

    // Credit / outstanding counters, status flags and the one-cycle read-return pipe
    always_ff @(posedge clk_ref or negedge rstn) begin
        if (!rstn) begin
            credits_q        <= CRED_W'(RSP_CREDITS);
            outst_q          <= '0;
            bus.io_err_ovf   <= 1'b0;
            bus.io_busy      <= 1'b0;
            bus.io_rsp_valid <= 1'b0;
            bus.io_rsp_data  <= '0;
            bus.io_rsp_last  <= 1'b0;
        end else begin
            credits_q        <= credits_d;
            outst_q          <= outst_d;
            bus.io_busy      <= (state_d != S_IDLE) || (outst_d != '0);
            if (ovf_hit) bus.io_err_ovf <= 1'b1;
            bus.io_rsp_valid <= bus.io_app_rdata_valid;
            bus.io_rsp_data  <= bus.io_app_rdata;
            bus.io_rsp_last  <= bus.io_app_rdata_valid && bus.io_app_rdata_end;
        end
    end

    logic unused_mask_w;
    assign unused_mask_w = (MASK_W == 0);
endmodule

// File: tb/tb_ddr3_app_sequencer.sv
// Directed self-checking bench for ddr3_app_sequencer: calibration gating, write bursts,
// pipelined reads, credit stall, overflow flag and reset during a write burst.
`timescale 1ns/1ps
module tb_ddr3_app_sequencer;
    localparam int unsigned DATA_W      = 128;
    localparam int unsigned ADDR_W      = 27;
    localparam int unsigned BURST_W     = 6;
    localparam int unsigned RSP_CREDITS = 64;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    ddr3_app_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

    ddr3_app_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W),
        .ADDR_STEP(8), .RSP_CREDITS(RSP_CREDITS)
    ) dut (
        .clk_ref (clk),
        .rstn    (rstn),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_wd_fire   = 0;
    int n_rd_issue  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] wbeat(input int b);
        return {4{32'hC0DE_0000 + 32'(b)}};
    endfunction

    function automatic logic [15:0] wmask(input int b);
        logic [15:0] base;
        base = 16'h00F0;
        return 16'h8001 ^ (base << b);
    endfunction

    function automatic logic [127:0] rbeat(input int k);
        return {4{32'hBEEF_0000 + 32'(k)}};
    endfunction

    // Observed app-side fires, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.io_app_wdata_en && bus.io_app_wdata_ready) n_wd_fire++;
        if (bus.io_app_cmd_en && bus.io_app_cmd_ready && bus.io_app_cmd[0]) n_rd_issue++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command from a fresh cycle and holds it until accepted (bounded)
    task automatic send_cmd(input string tag, input logic t, input logic [26:0] a,
                            input logic [5:0] b, input int maxw, output int waited);
        tick();
        bus.io_cmd_valid     = 1'b1;
        bus.io_cmd_type      = t;
        bus.io_cmd_addr      = a;
        bus.io_cmd_burst_cnt = b;
        waited = 0;
        @(negedge clk);
        while (!bus.io_cmd_ready && waited < maxw) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_accept"}, 128'(bus.io_cmd_ready), 128'(1));
        tick();
        bus.io_cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int wr_start;
        int rd_start;
        int beat;
        logic stalled;
        logic [5:0] rdy_seq;

        rstn = 1'b0;
        bus.io_cmd_valid = 1'b0;       bus.io_cmd_type = 1'b0;
        bus.io_cmd_addr = '0;          bus.io_cmd_burst_cnt = '0;
        bus.io_wd_valid = 1'b0;        bus.io_wd_data = '0;      bus.io_wd_mask = '0;
        bus.io_rsp_credit_ret = 1'b0;  bus.io_app_cmd_ready = 1'b0;
        bus.io_app_wdata_ready = 1'b0; bus.io_app_rdata = '0;
        bus.io_app_rdata_valid = 1'b0; bus.io_app_rdata_end = 1'b0;
        bus.io_init_calib_complete = 1'b0;

        // Reset state with a write already offered
        repeat (3) tick();
        bus.io_cmd_valid = 1'b1; bus.io_cmd_addr = 27'h100; bus.io_cmd_burst_cnt = 6'd3;
        @(negedge clk);
        chk("rst_cmd_ready", 128'(bus.io_cmd_ready), 128'(0));
        chk("rst_app_cmd_en", 128'(bus.io_app_cmd_en), 128'(0));
        chk("rst_busy", 128'(bus.io_busy), 128'(0));
        chk("rst_err_ovf", 128'(bus.io_err_ovf), 128'(0));
        chk("rst_rsp_valid", 128'(bus.io_rsp_valid), 128'(0));

        // Calibration gating: 20 cycles with calib low
        tick();
        rstn = 1'b1;
        stalled = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            stalled |= bus.io_cmd_ready | bus.io_app_cmd_en;
        end
        chk("calib_gate", 128'(stalled), 128'(0));
        chk("calib_busy", 128'(bus.io_busy), 128'(1));
        tick();
        bus.io_init_calib_complete = 1'b1;

        // Write burst: addr 0x100, burst_cnt 3, ready pattern 1,0,1,1,0,1
        send_cmd("wr0", 1'b0, 27'h100, 6'd3, 4, w);
        chk("calib_latency", 128'(w), 128'(0));
        @(negedge clk);
        chk("wcmd_en", 128'(bus.io_app_cmd_en), 128'(1));
        chk("wcmd_type", 128'(bus.io_app_cmd), 128'(0));
        chk("wcmd_addr", 128'(bus.io_app_addr), 128'(27'h100));
        chk("wcmd_burst", 128'(bus.io_app_burst_number), 128'(3));
        bus.io_app_cmd_ready = 1'b1;
        wr_start = n_wd_fire;
        beat = 0;
        rdy_seq = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.io_app_wdata_ready = rdy_seq[i];
            bus.io_wd_valid = 1'b1;
            bus.io_wd_data  = wbeat(beat);
            bus.io_wd_mask  = wmask(beat);
            @(negedge clk);
            chk($sformatf("w%0d_wd_ready", i), 128'(bus.io_wd_ready), 128'(rdy_seq[i]));
            chk($sformatf("w%0d_wdata_en", i), 128'(bus.io_app_wdata_en), 128'(1));
            chk($sformatf("w%0d_wdata", i), bus.io_app_wdata, wbeat(beat));
            chk($sformatf("w%0d_mask", i), 128'(bus.io_app_wdata_mask), 128'(wmask(beat)));
            chk($sformatf("w%0d_end", i), 128'(bus.io_app_wdata_end), 128'(beat == 3));
            if (rdy_seq[i]) beat++;
        end
        tick();
        bus.io_wd_valid = 1'b0;
        bus.io_app_wdata_ready = 1'b0;
        @(negedge clk);
        chk("wr_fire_count", 128'(n_wd_fire - wr_start), 128'(4));
        chk("wr_done_en", 128'(bus.io_app_wdata_en), 128'(0));
        chk("wr_done_busy", 128'(bus.io_busy), 128'(0));

        // Two pipelined reads, burst_cnt 7 each
        rd_start = n_rd_issue;
        send_cmd("rd0", 1'b1, 27'h200, 6'd7, 4, w);
        send_cmd("rd1", 1'b1, 27'h240, 6'd7, 4, w);
        chk("rd_back_to_back", 128'(w), 128'(0));
        @(negedge clk);
        chk("rd1_cmd_en", 128'(bus.io_app_cmd_en), 128'(1));
        chk("rd1_cmd_type", 128'(bus.io_app_cmd), 128'(1));
        chk("rd1_addr", 128'(bus.io_app_addr), 128'(27'h240));
        @(negedge clk);
        chk("rd_cmd_en_off", 128'(bus.io_app_cmd_en), 128'(0));
        chk("rd_issue_count", 128'(n_rd_issue - rd_start), 128'(2));
        chk("rd_no_wdata", 128'(n_wd_fire - wr_start), 128'(4));

        // 16 return beats, each seen one cycle later on rsp
        for (int k = 0; k <= 16; k++) begin
            tick();
            bus.io_app_rdata_valid = (k < 16);
            bus.io_app_rdata       = rbeat(k);
            bus.io_app_rdata_end   = (k == 7) || (k == 15);
            @(negedge clk);
            if (k >= 1) begin
                chk($sformatf("r%0d_valid", k - 1), 128'(bus.io_rsp_valid), 128'(1));
                chk($sformatf("r%0d_data", k - 1), bus.io_rsp_data, rbeat(k - 1));
                chk($sformatf("r%0d_last", k - 1), 128'(bus.io_rsp_last),
                    128'((k - 1 == 7) || (k - 1 == 15)));
            end
        end
        bus.io_app_rdata_end = 1'b0;
        chk("rd_done_busy", 128'(bus.io_busy), 128'(0));
        chk("rd_done_err", 128'(bus.io_err_ovf), 128'(0));

        // Stray beat with nothing outstanding
        tick();
        bus.io_app_rdata_valid = 1'b1;
        tick();
        bus.io_app_rdata_valid = 1'b0;
        @(negedge clk);
        chk("ovf_set", 128'(bus.io_err_ovf), 128'(1));
        repeat (5) @(negedge clk);
        chk("ovf_sticky", 128'(bus.io_err_ovf), 128'(1));

        // 48 credits left: a 48-beat read fits, a following 1-beat read must wait for a credit
        send_cmd("rd_fill", 1'b1, 27'h300, 6'd47, 4, w);
        chk("rd_fill_wait", 128'(w), 128'(0));
        bus.io_cmd_valid = 1'b1; bus.io_cmd_type = 1'b1;
        bus.io_cmd_addr = 27'h400; bus.io_cmd_burst_cnt = 6'd0;
        stalled = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            stalled |= bus.io_cmd_ready;
        end
        chk("credit_stall", 128'(stalled), 128'(0));
        tick();
        bus.io_cmd_valid = 1'b0;
        bus.io_rsp_credit_ret = 1'b1;
        tick();
        bus.io_rsp_credit_ret = 1'b0;
        send_cmd("rd_after_credit", 1'b1, 27'h400, 6'd0, 3, w);
        chk("rd_after_credit_wait", 128'(w), 128'(0));
        chk("ovf_still_set", 128'(bus.io_err_ovf), 128'(1));

        // Reset after 2 of 8 write beats
        send_cmd("wr_rst", 1'b0, 27'h500, 6'd7, 4, w);
        wr_start = n_wd_fire;
        bus.io_wd_valid = 1'b1;
        bus.io_wd_data  = wbeat(9);
        bus.io_wd_mask  = wmask(2);
        bus.io_app_wdata_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("wr_rst_two_beats", 128'(n_wd_fire - wr_start), 128'(2));
        rstn = 1'b0;
        bus.io_cmd_valid = 1'b1; bus.io_cmd_type = 1'b1;
        bus.io_cmd_addr = 27'h600; bus.io_cmd_burst_cnt = 6'd63;
        @(negedge clk);
        chk("mid_rst_cmd_ready", 128'(bus.io_cmd_ready), 128'(0));
        chk("mid_rst_wd_ready", 128'(bus.io_wd_ready), 128'(0));
        chk("mid_rst_wdata_en", 128'(bus.io_app_wdata_en), 128'(0));
        chk("mid_rst_wdata", bus.io_app_wdata, 128'(0));
        chk("mid_rst_mask", 128'(bus.io_app_wdata_mask), 128'(0));
        chk("mid_rst_cmd_en", 128'(bus.io_app_cmd_en), 128'(0));
        chk("mid_rst_addr", 128'(bus.io_app_addr), 128'(0));
        chk("mid_rst_busy", 128'(bus.io_busy), 128'(0));
        chk("mid_rst_err", 128'(bus.io_err_ovf), 128'(0));
        chk("mid_rst_rsp_valid", 128'(bus.io_rsp_valid), 128'(0));
        bus.io_wd_valid = 1'b0;
        bus.io_app_wdata_ready = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_calib_state", 128'(bus.io_cmd_ready), 128'(0));
        // Full 64-beat read accepted at once only if credits were restored
        send_cmd("rd_full", 1'b1, 27'h600, 6'd63, 3, w);
        chk("rd_full_wait", 128'(w), 128'(0));
        @(negedge clk);
        chk("rd_full_cmd_en", 128'(bus.io_app_cmd_en), 128'(1));
        chk("rd_full_type", 128'(bus.io_app_cmd), 128'(1));
        chk("rd_full_burst", 128'(bus.io_app_burst_number), 128'(63));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
